// File: rtl/uart_rx_if.sv
// Byte output port of the UART receiver: valid/ready handshake carrying one received word.
//   data   received word, stable while valid=1 and ready=0
//   valid  word available (producer -> consumer)
//   ready  consumer accepts the word when valid&ready at a rising clk edge
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversamples an asynchronous idle-high rx line and frames start bit,
// DATA_BITS data bits LSB first and one stop bit; received words leave on a valid/ready port.
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   port       uart_rx_if master: data/valid out, ready in
//   frame_err  one-cycle pulse when the stop bit is sampled low
//   overrun    one-cycle pulse when a word completes while the previous one is still held
//   busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CNT_W        = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master port,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);

    localparam int unsigned H     = CLKS_PER_BIT / 2;
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    // Elaboration-time parameter sanity
    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_db
        $error("uart_rx: DATA_BITS must be 5..8");
    end
    if ((2 ** CNT_W) <= (CLKS_PER_BIT - 1)) begin : g_bad_cnt
        $error("uart_rx: CNT_W too narrow for CLKS_PER_BIT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 rx_m, rx_s;
    logic                 deliver_c;
    logic                 ferr_c;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // FSM and datapath state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    // Next-state: start is checked at mid-bit (H-1), then every bit is sampled one full
    // period later, which lands each sample in the middle of its bit.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        deliver_c   = 1'b0;
        ferr_c      = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end

            S_START: begin
                if (cnt == CNT_W'(H - 1)) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = S_DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        // Line went back high before mid-bit: glitch, not a frame
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_s, shift[DATA_BITS-1:1]};
                    bit_idx_nxt = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_nxt = S_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        deliver_c = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        ferr_c    = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            S_BREAK: begin
                // Hold here while the line stays low so a long break reports once
                if (rx_s) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output port: a new word may replace the held one only in the cycle it is being accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port.data  <= '0;
            port.valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= ferr_c;
            overrun   <= 1'b0;
            busy      <= (state_nxt != S_IDLE);
            if (deliver_c) begin
                if (!port.valid || port.ready) begin
                    port.data  <= shift;
                    port.valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (port.valid && port.ready) begin
                port.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven on rx, expected words are queued as frames
// are sent, and a monitor pops and compares on every accepted word.
module tb_uart_rx;

    localparam int unsigned CPB = 4;
    localparam int unsigned DB  = 8;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .CNT_W       (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .port     (bus),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    int         ferr_seen = 0;
    int         ovr_seen = 0;
    int         ferr_exp = 0;
    int         ovr_exp = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge values hold through the next edge
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h, expected none (t=%0t)", bus.data, $time);
                end else begin
                    check("rx_word", 32'(bus.data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Drive one frame starting at posedge+1; returns at posedge+1 with rx at the stop level
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_good(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_ferr"}, 32'(ferr_seen), 32'(ferr_exp));
        check({tag, "_ovr"}, 32'(ovr_seen), 32'(ovr_exp));
        check({tag, "_qlen"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst       = 1'b0;
        rx        = 1'b1;
        bus.ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b1;
        idle(5);

        // Single frame: valid first seen 41 cycles after rx falls
        fork
            begin : t_send
                exp_q.push_back(8'hA5);
                send_frame(8'hA5, 1'b1);
            end
            begin : t_lat
                int k;
                k = 0;
                while (!bus.valid && k < 100) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                check("latency", 32'(k), 32'd41);
            end
        join
        idle(10);
        check("a5_busy", 32'(busy), 32'd0);
        check_counts("a5");

        // One-cycle low glitch on rx
        rx = 1'b0;
        @(posedge clk);
        #1;
        idle(8);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_valid", 32'(bus.valid), 32'd0);
        check_counts("glitch");

        // Low stop bit followed by a long break, then a clean frame
        ferr_exp++;
        send_frame(8'h3C, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        idle(8);
        check("break_valid", 32'(bus.valid), 32'd0);
        send_good(8'h81);
        idle(10);
        check_counts("break");

        // Consumer stalled across two back-to-back frames
        bus.ready = 1'b0;
        exp_q.push_back(8'h11);
        ovr_exp++;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(6);
        check("ovr_valid", 32'(bus.valid), 32'd1);
        check("ovr_data", 32'(bus.data), 32'h11);
        check("ovr_cnt", 32'(ovr_seen), 32'(ovr_exp));
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drop", 32'(bus.valid), 32'd0);
        check_counts("ovr");

        // Handshake of the first word lands on the stop-sample edge of the second frame
        bus.ready = 1'b0;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        fork
            begin : c_send
                send_frame(8'h33, 1'b1);
                send_frame(8'h44, 1'b1);
            end
            begin : c_ready
                repeat (80) @(posedge clk);
                #1;
                bus.ready = 1'b1;
            end
        join
        idle(6);
        check("coll_valid", 32'(bus.valid), 32'd0);
        check_counts("coll");

        // Reset in the middle of a frame's data bits
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_valid", 32'(bus.valid), 32'd0);
        check("mrst_data", 32'(bus.data), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ferr", 32'(frame_err), 32'd0);
        check("mrst_ovr", 32'(overrun), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5);
        send_good(8'h5A);
        idle(10);
        check_counts("mrst");

        // Random frames with occasional bad stop bits and random gaps
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ferr_exp++;
                send_frame(b, 1'b0);
                repeat ($urandom_range(0, 10)) @(posedge clk);
                #1;
                idle($urandom_range(2, 6));
            end else begin
                send_good(b);
                idle($urandom_range(0, 5));
            end
        end
        idle(20);
        check("end_busy", 32'(busy), 32'd0);
        check_counts("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
